// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   state_e        : controller state (IDLE, MD_WAIT)
//   REG_ZERO       : architectural zero register; never a real dependency
//   MULDIV_LAT_MIN : smallest legal mul/div occupancy of EX
//   MULDIV_LAT_MAX : largest legal occupancy (bounded by the 4-bit wait counter)
package hazard_ctrl_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MD_WAIT = 1'b1
  } state_e;

  localparam logic [4:0] REG_ZERO       = 5'd0;
  localparam int         MULDIV_LAT_MIN = 1;
  localparam int         MULDIV_LAT_MAX = 16;

  function automatic bit muldiv_lat_ok(input int lat);
    return (lat >= MULDIV_LAT_MIN) && (lat <= MULDIV_LAT_MAX);
  endfunction

endpackage

// File: rtl/hazard_lu_detect.sv
// Load-use dependency detector (purely combinational).
// Flags when the load now in EX writes a register that the instruction in ID
// reads. rt only matters when the ID instruction actually reads rt.
//   ID_EX_MemRead : EX instruction is a load
//   ID_EX_rt      : load destination register
//   IF_ID_rs      : rs field of ID instruction
//   IF_ID_rt      : rt field of ID instruction
//   IF_ID_UsesRt  : ID instruction reads rt
//   LoadUse       : load-use hazard present
module hazard_lu_detect
  import hazard_ctrl_pkg::*;
(
  input  logic       ID_EX_MemRead,
  input  logic [4:0] ID_EX_rt,
  input  logic [4:0] IF_ID_rs,
  input  logic [4:0] IF_ID_rt,
  input  logic       IF_ID_UsesRt,
  output logic       LoadUse
);

  logic rs_match;
  logic rt_match;

  assign rs_match = (ID_EX_rt == IF_ID_rs);
  assign rt_match = IF_ID_UsesRt && (ID_EX_rt == IF_ID_rt);
  assign LoadUse  = ID_EX_MemRead && (ID_EX_rt != REG_ZERO) && (rs_match || rt_match);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: single source of the PC, IF/ID, ID/EX and
// EX/MEM control strobes. Handles load-use stalls, wrong-path squash after a
// jump resolved in EX, and front-end freeze during a multi-cycle mul/div.
//
// Parameters:
//   MULDIV_LATENCY : cycles a mul/div occupies EX (1..16)
//   CNT_W          : width of StallCount
// Ports:
//   Clk, Rst_n                          clock, async active-low reset
//   ID_EX_MemRead, ID_EX_rt, ID_EX_jump EX-stage instruction info
//   MulDivStart                         first EX cycle of a mul/div
//   IF_ID_rs, IF_ID_rt, IF_ID_UsesRt    ID-stage operand info
//   PCWrite, IF_ID_Write, IF_ID_Flush,
//   ID_EX_Bubble, ID_EX_Hold,
//   EX_MEM_Bubble                       pipeline control strobes (Mealy)
//   StallCount                          stalled-cycle counter
// Optional feature macro:
//   HAZARD_PERF_EN : when defined, StallCount counts PCWrite=0 cycles
//                    (saturating); otherwise StallCount is tied to 0.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | normal flow; MD, jump, LU resolved in that priority
// MD_WAIT | mul/div still occupying EX; front end frozen, cnt counts down
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULDIV_LATENCY = 4,
  parameter int CNT_W          = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_rt,
  input  logic             ID_EX_jump,
  input  logic             MulDivStart,
  input  logic [4:0]       IF_ID_rs,
  input  logic [4:0]       IF_ID_rt,
  input  logic             IF_ID_UsesRt,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Bubble,
  output logic             ID_EX_Hold,
  output logic             EX_MEM_Bubble,
  output logic [CNT_W-1:0] StallCount
);

  generate
    if (!muldiv_lat_ok(MULDIV_LATENCY)) begin : g_bad_latency
      $error("hazard_ctrl: MULDIV_LATENCY out of range 1..16");
    end
  endgenerate

  // A latency of 1 needs no stall; 2 needs only the start cycle; 3+ also
  // needs the wait state, which then lasts MULDIV_LATENCY-2 cycles.
  localparam bit         MD_EN      = (MULDIV_LATENCY >= 2);
  localparam bit         MD_WAIT_EN = (MULDIV_LATENCY >= 3);
  localparam logic [3:0] CNT_INIT   = MD_WAIT_EN ? 4'(MULDIV_LATENCY - 3) : 4'd0;

  state_e     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       load_use;
  logic       md;

  hazard_lu_detect u_lu (
    .ID_EX_MemRead (ID_EX_MemRead),
    .ID_EX_rt      (ID_EX_rt),
    .IF_ID_rs      (IF_ID_rs),
    .IF_ID_rt      (IF_ID_rt),
    .IF_ID_UsesRt  (IF_ID_UsesRt),
    .LoadUse       (load_use)
  );

  assign md = MulDivStart && MD_EN;

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    PCWrite       = 1'b1;
    IF_ID_Write   = 1'b1;
    IF_ID_Flush   = 1'b0;
    ID_EX_Bubble  = 1'b0;
    ID_EX_Hold    = 1'b0;
    EX_MEM_Bubble = 1'b0;
    if (!Rst_n) begin
      // Reset holds the pipeline empty: nothing advances, nothing enters.
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      IF_ID_Flush  = 1'b1;
      ID_EX_Bubble = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (md) begin
            PCWrite       = 1'b0;
            IF_ID_Write   = 1'b0;
            ID_EX_Hold    = 1'b1;
            EX_MEM_Bubble = 1'b1;
            if (MD_WAIT_EN) begin
              state_nxt = MD_WAIT;
              cnt_nxt   = CNT_INIT;
            end
          end else if (ID_EX_jump) begin
            IF_ID_Flush  = 1'b1;
            ID_EX_Bubble = 1'b1;
          end else if (load_use) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
          end
        end
        MD_WAIT: begin
          // Jump/LU stay visible in the held ID/EX and are handled after exit.
          PCWrite       = 1'b0;
          IF_ID_Write   = 1'b0;
          ID_EX_Hold    = 1'b1;
          EX_MEM_Bubble = 1'b1;
          if (cnt == 4'd0) begin
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt - 4'd1;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stall_cnt <= '0;
    end else if (!PCWrite && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign StallCount = stall_cnt;
`else
  assign StallCount = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. Three instances share the stimulus:
// MULDIV_LATENCY = 4 (main), 1 and 2 (edge latencies). Expected strobes are
// queued when inputs are applied and popped when outputs are sampled.
// Strobe vectors are {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble,
// ID_EX_Hold, EX_MEM_Bubble}.
module tb_hazard_ctrl;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       ID_EX_MemRead = 1'b0;
  logic [4:0] ID_EX_rt = 5'd0;
  logic       ID_EX_jump = 1'b0;
  logic       MulDivStart = 1'b0;
  logic [4:0] IF_ID_rs = 5'd0;
  logic [4:0] IF_ID_rt = 5'd0;
  logic       IF_ID_UsesRt = 1'b0;

  logic [5:0]  o4, o1, o2;
  logic [15:0] c4, c1, c2;

  always #5 Clk = ~Clk;

  hazard_ctrl #(.MULDIV_LATENCY(4), .CNT_W(16)) dut4 (
    .Clk(Clk), .Rst_n(Rst_n), .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_rt(ID_EX_rt),
    .ID_EX_jump(ID_EX_jump), .MulDivStart(MulDivStart), .IF_ID_rs(IF_ID_rs),
    .IF_ID_rt(IF_ID_rt), .IF_ID_UsesRt(IF_ID_UsesRt),
    .PCWrite(o4[5]), .IF_ID_Write(o4[4]), .IF_ID_Flush(o4[3]), .ID_EX_Bubble(o4[2]),
    .ID_EX_Hold(o4[1]), .EX_MEM_Bubble(o4[0]), .StallCount(c4));

  hazard_ctrl #(.MULDIV_LATENCY(1), .CNT_W(16)) dut1 (
    .Clk(Clk), .Rst_n(Rst_n), .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_rt(ID_EX_rt),
    .ID_EX_jump(ID_EX_jump), .MulDivStart(MulDivStart), .IF_ID_rs(IF_ID_rs),
    .IF_ID_rt(IF_ID_rt), .IF_ID_UsesRt(IF_ID_UsesRt),
    .PCWrite(o1[5]), .IF_ID_Write(o1[4]), .IF_ID_Flush(o1[3]), .ID_EX_Bubble(o1[2]),
    .ID_EX_Hold(o1[1]), .EX_MEM_Bubble(o1[0]), .StallCount(c1));

  hazard_ctrl #(.MULDIV_LATENCY(2), .CNT_W(16)) dut2 (
    .Clk(Clk), .Rst_n(Rst_n), .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_rt(ID_EX_rt),
    .ID_EX_jump(ID_EX_jump), .MulDivStart(MulDivStart), .IF_ID_rs(IF_ID_rs),
    .IF_ID_rt(IF_ID_rt), .IF_ID_UsesRt(IF_ID_UsesRt),
    .PCWrite(o2[5]), .IF_ID_Write(o2[4]), .IF_ID_Flush(o2[3]), .ID_EX_Bubble(o2[2]),
    .ID_EX_Hold(o2[1]), .EX_MEM_Bubble(o2[0]), .StallCount(c2));

  localparam logic [5:0] DEF = 6'b110000;
  localparam logic [5:0] LU  = 6'b000100;
  localparam logic [5:0] JMP = 6'b111100;
  localparam logic [5:0] MD  = 6'b000011;
  localparam logic [5:0] RST = 6'b001100;

  typedef struct {
    string      tag;
    logic [5:0] e4;
    logic [5:0] e1;
    logic [5:0] e2;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   sc4 = 0, sc1 = 0, sc2 = 0;

  task automatic chk_o(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: strobes got %b want %b", tag, obs, exp);
    end
  endtask

  task automatic chk_c(input string tag, input logic [15:0] obs, input int model);
    logic [15:0] exp;
`ifdef HAZARD_PERF_EN
    exp = model[15:0];
`else
    exp = 16'd0;
`endif
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: StallCount got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic mr, input logic [4:0] ert, input logic jmp,
                     input logic mds, input logic [4:0] rs, input logic [4:0] rt,
                     input logic uses, input string tag,
                     input logic [5:0] e4, input logic [5:0] e1, input logic [5:0] e2);
    exp_t x;
    @(negedge Clk);
    ID_EX_MemRead = mr;
    ID_EX_rt      = ert;
    ID_EX_jump    = jmp;
    MulDivStart   = mds;
    IF_ID_rs      = rs;
    IF_ID_rt      = rt;
    IF_ID_UsesRt  = uses;
    sb.push_back('{tag, e4, e1, e2});
    #2;
    x = sb.pop_front();
    chk_o({x.tag, "/L4"}, o4, x.e4);
    chk_o({x.tag, "/L1"}, o1, x.e1);
    chk_o({x.tag, "/L2"}, o2, x.e2);
    chk_c({x.tag, "/cnt4"}, c4, sc4);
    chk_c({x.tag, "/cnt1"}, c1, sc1);
    chk_c({x.tag, "/cnt2"}, c2, sc2);
    // Counters advance at the coming rising edge for each stalled cycle.
    if (!x.e4[5]) sc4++;
    if (!x.e1[5]) sc1++;
    if (!x.e2[5]) sc2++;
  endtask

  initial begin
    #2;
    chk_o("reset/L4", o4, RST);
    chk_o("reset/L1", o1, RST);
    chk_o("reset/L2", o2, RST);
    chk_c("reset/cnt4", c4, 0);

    @(negedge Clk);
    Rst_n = 1'b1;

    //   mr   ert    jmp  mds  rs     rt     uses tag          L4   L1   L2
    cyc(1'b1, 5'd8, 1'b0, 1'b0, 5'd8, 5'd0, 1'b0, "lu_rs",     LU,  LU,  LU);
    cyc(1'b0, 5'd8, 1'b0, 1'b0, 5'd8, 5'd0, 1'b0, "lu_clear",  DEF, DEF, DEF);
    cyc(1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, "r0_nohaz",  DEF, DEF, DEF);
    cyc(1'b1, 5'd9, 1'b0, 1'b0, 5'd3, 5'd9, 1'b0, "rt_unused", DEF, DEF, DEF);
    cyc(1'b1, 5'd9, 1'b0, 1'b0, 5'd3, 5'd9, 1'b1, "lu_rt",     LU,  LU,  LU);
    cyc(1'b1, 5'd8, 1'b1, 1'b0, 5'd8, 5'd0, 1'b0, "jmp_vs_lu", JMP, JMP, JMP);
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, "idle",      DEF, DEF, DEF);

    // Mul/div; jump and LU arrive during the freeze and act after release.
    cyc(1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, "md_T",      MD,  DEF, MD);
    cyc(1'b1, 5'd8, 1'b1, 1'b0, 5'd8, 5'd0, 1'b0, "md_T1",     MD,  JMP, JMP);
    cyc(1'b1, 5'd8, 1'b1, 1'b0, 5'd8, 5'd0, 1'b0, "md_T2",     MD,  JMP, JMP);
    cyc(1'b1, 5'd8, 1'b1, 1'b0, 5'd8, 5'd0, 1'b0, "md_T3",     JMP, JMP, JMP);
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, "md_after",  DEF, DEF, DEF);

    // MD beats jump; a repeated start inside MD_WAIT must not extend it.
    cyc(1'b0, 5'd0, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, "md2_T",     MD,  JMP, MD);
    cyc(1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, "md2_T1",    MD,  DEF, MD);
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, "md2_T2",    MD,  DEF, DEF);
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, "md2_T3",    DEF, DEF, DEF);

    // Asynchronous reset in the middle of MD_WAIT.
    cyc(1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, "md3_T",     MD,  DEF, MD);
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, "md3_T1",    MD,  DEF, DEF);
    #1;
    Rst_n = 1'b0;
    #1;
    chk_o("async_rst/L4", o4, RST);
    chk_o("async_rst/L1", o1, RST);
    chk_o("async_rst/L2", o2, RST);
    chk_c("async_rst/cnt4", c4, 0);
    sc4 = 0;
    sc1 = 0;
    sc2 = 0;
    @(negedge Clk);
    Rst_n = 1'b1;
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, "post_rst",  DEF, DEF, DEF);
    cyc(1'b1, 5'd5, 1'b0, 1'b0, 5'd5, 5'd0, 1'b0, "post_lu",   LU,  LU,  LU);
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, "final",     DEF, DEF, DEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
